mem_access_unit: RTL and testbench

Memory-stage load/store controller for the MIPS datapath. It sits directly upstream of the writeback result select. It takes the EX-stage address (ALUresult), store data and access size, and runs a req/ready transaction on the data-memory bus. It stalls the pipeline until the transaction completes, then presents the aligned, sign/zero-extended load value on `mem_out` for the writeback select.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/load_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MEM-stage load/store controller.
//   mem_size_t  : access size encoding as carried down the pipeline
//   mau_state_t : controller FSM states
//   calc_be     : byte enables for a size/offset pair (little-endian lanes)
//   calc_wdata  : lane-replicated store data for a size
//   is_aligned  : natural-alignment test for a size/offset pair
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } mau_state_t;

  // Encoding 2'b11 falls into the default arm and behaves as a word access.
  function automatic logic [3:0] calc_be(input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Narrow stores are replicated across all lanes so the memory only has to
  // honour the byte enables; it never needs to shift the data.
  function automatic logic [31:0] calc_wdata(input logic [1:0]  size,
                                             input logic [31:0] sd);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{sd[7:0]}};
      SZ_HALF: wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the MEM-stage controller (master) and the memory
// (slave).
//   bus_req   : transaction request
//   bus_we    : 1 = write
//   bus_addr  : word-aligned byte address, [1:0] always 00
//   bus_be    : byte enables, bit i = byte lane i
//   bus_wdata : lane-replicated write data
//   bus_rdata : read word from memory
//   bus_ready : completes the transaction in the cycle it is seen with bus_req
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data extractor: picks the addressed byte or halfword out
// of a bus read word and sign- or zero-extends it to 32 bits.
//   rdata       : read word from the bus (little-endian lanes)
//   offset      : byte offset within the word (addr[1:0])
//   size        : 00 byte, 01 half, 10/11 word
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   ext         : extended 32-bit load value
// ---------------------------------------------------------------------------
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    // A halfword access is aligned, so only addr[1] selects the lane.
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: ext = is_unsigned ? {24'b0, byte_s} : 32'(byte_s);
      SZ_HALF: ext = is_unsigned ? {16'b0, half_s} : 32'(half_s);
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store controller. Accepts the EX-stage effective address,
// store data and access size, runs one req/ready transaction on the data
// bus, stalls the pipeline until it completes and presents the aligned,
// extended load value on mem_out for the writeback select.
//   clk, rst_n   : clock, synchronous active-low reset
//   mem_en       : instruction in MEM is a load/store
//   mem_wen      : 1 = store, 0 = load
//   mem_size     : 00 byte, 01 half, 10/11 word
//   mem_unsigned : zero-extend loads when set
//   ALUresult    : effective byte address
//   store_data   : rt value for stores
//   mem_out      : registered load result, holds until the next load retires
//   stall        : freezes the upstream pipeline registers
//   addr_err     : high while a misaligned access sits in MEM
//   bus          : data-memory bus, master side
// Flow: IDLE (accept) -> BUS (until bus_ready) -> DONE -> IDLE.
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_en,
  input  logic                    mem_wen,
  input  logic [1:0]              mem_size,
  input  logic                    mem_unsigned,
  input  logic [31:0]             ALUresult,
  input  logic [31:0]             store_data,
  output logic [31:0]             mem_out,
  output logic                    stall,
  output logic                    addr_err,
  mem_access_unit_if.master       bus
);

  mau_state_t        state_q, state_d;
  logic              aligned;
  logic              accept;
  logic              rd_done;

  logic [ADDR_W-1:0] addr_p1;
  logic [3:0]        be_p1;
  logic [31:0]       wdata_p1;
  logic              we_p1;
  logic [1:0]        size_p1;
  logic [1:0]        off_p1;
  logic              uns_p1;

  logic [31:0]       load_val;
  logic [31:0]       mem_out_p2;

  assign aligned = is_aligned(mem_size, ALUresult[1:0]);

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    stall         = 1'b0;
    addr_err      = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = '0;
    bus.bus_wdata = '0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          if (aligned) begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = BUS;
          end else begin
            // Misaligned: flag it and let the instruction leave MEM untouched.
            addr_err = 1'b1;
          end
        end
      end
      BUS: begin
        // mem_en is not consulted here; a started transaction always finishes.
        stall         = 1'b1;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_p1;
        bus.bus_addr  = addr_p1;
        bus.bus_be    = be_p1;
        bus.bus_wdata = wdata_p1;
        if (bus.bus_ready) state_d = DONE;
      end
      DONE: begin
        // stall is low so the pipeline advances; mem_en still belongs to the
        // retiring instruction, hence no accept here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- stage p1: request captured at accept, held stable through BUS ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= {ALUresult[ADDR_W-1:2], 2'b00};
      be_p1    <= calc_be(mem_size, ALUresult[1:0]);
      wdata_p1 <= calc_wdata(mem_size, store_data);
      we_p1    <= mem_wen;
      size_p1  <= mem_size;
      off_p1   <= ALUresult[1:0];
      uns_p1   <= mem_unsigned;
    end
  end

  load_align u_load_align (
    .rdata       (bus.bus_rdata),
    .offset      (off_p1),
    .size        (size_p1),
    .is_unsigned (uns_p1),
    .ext         (load_val)
  );

  assign rd_done = (state_q == BUS) && bus.bus_ready && !we_p1;

  // ---- stage p2: load result register feeding writeback select ----
  // Reset clears it too, so a read captured during a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n)       mem_out_p2 <= '0;
    else if (rd_done) mem_out_p2 <= load_val;
  end

  assign mem_out = mem_out_p2;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] ALUresult;
  logic [31:0] store_data;
  logic [31:0] mem_out;
  logic        stall;
  logic        addr_err;

  mem_access_unit_if #(.ADDR_W(32)) bus_if ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .ALUresult    (ALUresult),
    .store_data   (store_data),
    .mem_out      (mem_out),
    .stall        (stall),
    .addr_err     (addr_err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  int   ready_delay = 0;
  logic force_ready = 1'b0;
  int   bcnt = 0;

  always @(posedge clk) begin
    #2;
    if (bus_if.bus_req) begin
      bus_if.bus_ready = (bcnt >= ready_delay);
      bcnt++;
    end else begin
      bus_if.bus_ready = force_ready;
      bcnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] out;
    string       name;
  } exp_t;

  exp_t  txq[$];
  string errq[$];
  logic        out_pend = 1'b0;
  logic [31:0] out_pend_val = '0;
  string       out_pend_name = "";

  always @(negedge clk) begin
    exp_t  e;
    string en;
    if (out_pend) begin
      check({out_pend_name, "_mem_out"}, mem_out, out_pend_val);
      check({out_pend_name, "_done_stall"}, {31'b0, stall}, 32'd0);
      out_pend = 1'b0;
    end
    if (bus_if.bus_req && bus_if.bus_ready) begin
      if (txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_txn got addr %08h expected no transaction", bus_if.bus_addr);
      end else begin
        e = txq.pop_front();
        check({e.name, "_bus_addr"},  bus_if.bus_addr, e.addr);
        check({e.name, "_bus_be"},    {28'b0, bus_if.bus_be}, {28'b0, e.be});
        check({e.name, "_bus_wdata"}, bus_if.bus_wdata, e.wdata);
        check({e.name, "_bus_we"},    {31'b0, bus_if.bus_we}, {31'b0, e.we});
        out_pend      = 1'b1;
        out_pend_val  = e.out;
        out_pend_name = e.name;
      end
    end
    if (addr_err) begin
      if (errq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_addr_err got 1 expected 0");
      end else begin
        en = errq.pop_front();
        check({en, "_err_bus_req"}, {31'b0, bus_if.bus_req}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input string name, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic we, input logic [31:0] sd,
                        input logic [31:0] rdata, input int delay,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_out,
                        input int exp_stall);
    exp_t e;
    int   n;
    logic held, first;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    e.addr = exp_addr; e.be = exp_be; e.wdata = exp_wdata; e.we = we;
    e.out = exp_out; e.name = name;
    txq.push_back(e);
    @(posedge clk); #1;
    ready_delay      = delay;
    bus_if.bus_rdata = rdata;
    mem_en = 1'b1; mem_wen = we; mem_size = size; mem_unsigned = uns;
    ALUresult = addr; store_data = sd;
    n = 0; held = 1'b1; first = 1'b1;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (bus_if.bus_req) begin
        if (first) begin
          a0 = bus_if.bus_addr; w0 = bus_if.bus_wdata; b0 = bus_if.bus_be; we0 = bus_if.bus_we;
          first = 1'b0;
        end else if (bus_if.bus_addr !== a0 || bus_if.bus_wdata !== w0 ||
                     bus_if.bus_be !== b0 || bus_if.bus_we !== we0) begin
          held = 1'b0;
        end
      end
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    if (exp_stall > 2) check({name, "_bus_held"}, {31'b0, held}, 32'd1);
    @(posedge clk); #1;
    mem_en = 1'b0;
  endtask

  task automatic misaligned(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] exp_out);
    errq.push_back(name);
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wen = 1'b0; mem_size = size; mem_unsigned = 1'b0;
    ALUresult = addr; store_data = '0;
    @(negedge clk);
    check({name, "_addr_err"}, {31'b0, addr_err}, 32'd1);
    check({name, "_stall"},    {31'b0, stall},    32'd0);
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    check({name, "_addr_err_pulse"}, {31'b0, addr_err}, 32'd0);
    check({name, "_bus_req"},  {31'b0, bus_if.bus_req}, 32'd0);
    check({name, "_mem_out"},  mem_out, exp_out);
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_wen = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    ALUresult = '0; store_data = '0;
    bus_if.bus_rdata = '0; bus_if.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_out",   mem_out, 32'h0);
    check("rst_stall",     {31'b0, stall}, 32'd0);
    check("rst_addr_err",  {31'b0, addr_err}, 32'd0);
    check("rst_bus_req",   {31'b0, bus_if.bus_req}, 32'd0);
    check("rst_bus_we",    {31'b0, bus_if.bus_we}, 32'd0);
    check("rst_bus_addr",  bus_if.bus_addr, 32'h0);
    check("rst_bus_be",    {28'b0, bus_if.bus_be}, 32'h0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);

    //      name     addr          sz     uns   we    sd            rdata         dly bus_addr      be       wdata         mem_out       stall
    access("lw100", 32'h100, 2'b10, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 2);
    access("lb103", 32'h103, 2'b00, 1'b0, 1'b0, 32'h0,        32'h80FF0011, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 2);
    access("lbu103",32'h103, 2'b00, 1'b1, 1'b0, 32'h0,        32'h80FF0011, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 2);
    access("sh202", 32'h202, 2'b01, 1'b0, 1'b1, 32'h1234ABCD, 32'h55555555, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, 2);
    access("lw40w3",32'h040, 2'b10, 1'b0, 1'b0, 32'h0,        32'h11223344, 3, 32'h040, 4'b1111, 32'h0,        32'h11223344, 5);
    misaligned("lh101", 32'h101, 2'b01, 32'h11223344);
    access("lh102", 32'h102, 2'b01, 1'b0, 1'b0, 32'h0,        32'h80FF0011, 0, 32'h100, 4'b1100, 32'h0,        32'hFFFF80FF, 2);
    access("lhu100",32'h100, 2'b01, 1'b1, 1'b0, 32'h0,        32'h80FF0011, 1, 32'h100, 4'b0011, 32'h0,        32'h00000011, 3);
    access("sb001", 32'h001, 2'b00, 1'b0, 1'b1, 32'hFFFFFFA5, 32'h0,        0, 32'h000, 4'b0010, 32'hA5A5A5A5, 32'h00000011, 2);
    misaligned("lw102", 32'h102, 2'b10, 32'h00000011);
    access("sz11",  32'h014, 2'b11, 1'b0, 1'b0, 32'h0,        32'hCAFEF00D, 0, 32'h014, 4'b1111, 32'h0,        32'hCAFEF00D, 2);
    access("sw20",  32'h020, 2'b10, 1'b0, 1'b1, 32'h87654321, 32'h0,        2, 32'h020, 4'b1111, 32'h87654321, 32'hCAFEF00D, 4);

    // bus_ready while idle must be ignored
    @(posedge clk); #1;
    force_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_rdy_stall",   {31'b0, stall}, 32'd0);
    check("idle_rdy_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
    check("idle_rdy_mem_out", mem_out, 32'hCAFEF00D);
    @(posedge clk); #1;
    force_ready = 1'b0;
    @(posedge clk);

    // reset asserted while a transaction is waiting in BUS
    @(posedge clk); #1;
    ready_delay = 100; bus_if.bus_rdata = 32'h99999999;
    mem_en = 1'b1; mem_wen = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    ALUresult = 32'h300; store_data = '0;
    @(negedge clk);
    check("rstbus_accept_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbus_in_bus_req", {31'b0, bus_if.bus_req}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstbus_bus_req", {31'b0, bus_if.bus_req}, 32'd0);
    check("rstbus_mem_out", mem_out, 32'h0);
    check("rstbus_stall",   {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("lbu003",32'h003, 2'b00, 1'b1, 1'b0, 32'h0,        32'hF0000000, 0, 32'h000, 4'b1000, 32'h0,        32'h000000F0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("txq_drained",  txq.size(),  32'd0);
    check("errq_drained", errq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
